// File: rtl/mem_write_checker_if.sv
// Core data-memory write bus (MemWrite, DataAdr, WriteData) as seen by the run checker.
// The core side drives it through the master modport; the checker observes it through slave.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker.sv
// Run control and write-bus checker for the ARMv4 core: reset pulse, PASS/FAIL/TIMEOUT verdict, statistics.
// Define MON_HISTORY_EN to build the HIST_DEPTH-entry write history; otherwise hist_* read 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_HOLD   | core held in reset for RST_CYCLES cycles
// S_RUN    | core running; writes counted, verdict address watched
// S_PASS   | verdict write carried PASS_DATA; core frozen
// S_FAIL   | verdict write carried other data; core frozen
// S_TIMEOUT| no verdict write within TIMEOUT_CYCLES; core frozen
module mem_write_checker #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                RST_CYCLES     = 3,
  parameter logic [ADDR_W-1:0] PASS_ADDR      = 100,
  parameter logic [DATA_W-1:0] PASS_DATA      = 7,
  parameter int                TIMEOUT_CYCLES = 4096,
  parameter int                CNT_W          = 16,
  parameter int                HIST_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  mem_write_checker_if.slave            bus,
  output logic                          cpu_rst,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [CNT_W-1:0]              write_count,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [ADDR_W-1:0]             last_addr,
  output logic [DATA_W-1:0]             last_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [ADDR_W-1:0]             hist_addr,
  output logic [DATA_W-1:0]             hist_data
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              hit_addr;
  logic              hit_data;

  assign accept   = (state == S_RUN) && bus.mem_write;
  assign hit_addr = (bus.data_adr == PASS_ADDR);
  assign hit_data = (bus.write_data == PASS_DATA);

  // Counter width must cover the timeout compare value.
  always @(posedge clk) begin
    assert (longint'(TIMEOUT_CYCLES) <= (64'd1 << CNT_W))
      else $error("mem_write_checker: TIMEOUT_CYCLES exceeds 2**CNT_W");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      cpu_rst     <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      write_count <= '0;
      cycle_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Stops at the timeout compare value so a timed-out run reports TIMEOUT_CYCLES-1.
          if (cycle_count != TO_LAST && cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
          if (accept) begin
            if (write_count != '1)
              write_count <= write_count + 1'b1;
            last_addr <= bus.data_adr;
            last_data <= bus.write_data;
          end
          if (accept && hit_addr) begin
            cpu_rst <= 1'b1;
            done    <= 1'b1;
            if (hit_data) begin
              state <= S_PASS;
              pass  <= 1'b1;
            end else begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end
          end else if (cycle_count == TO_LAST) begin
            state   <= S_TIMEOUT;
            cpu_rst <= 1'b1;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MON_HISTORY_EN
  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [ADDR_W-1:0] hist_a [HIST_DEPTH];
  logic [DATA_W-1:0] hist_d [HIST_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_a[i] <= '0;
        hist_d[i] <= '0;
      end
    end else if (accept) begin
      hist_a[wr_ptr] <= bus.data_adr;
      hist_d[wr_ptr] <= bus.write_data;
      wr_ptr         <= wr_ptr + 1'b1;
    end
  end

  // wr_ptr points at the next free slot; index 0 is the slot just behind it.
  assign rd_ptr    = wr_ptr - IDX_W'(1) - hist_idx;
  assign hist_addr = hist_a[rd_ptr];
  assign hist_data = hist_d[rd_ptr];
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_addr = '0;
  assign hist_data = '0;
`endif

endmodule
